// File: rtl/vga_timing_if.sv
// Raster timing bundle driven by vga_timing_generator and consumed by the display controller.
interface vga_timing_if #(
    parameter int ADDR_W = 19
);
    logic              oHS;
    logic              oVS;
    logic              oBLANK_n;
    logic [9:0]        oX;
    logic [9:0]        oY;
    logic [ADDR_W-1:0] oADDR;
    logic              oLINE_START;
    logic              oFRAME_START;

    modport master (
        output oHS, oVS, oBLANK_n, oX, oY, oADDR, oLINE_START, oFRAME_START
    );
    modport slave (
        input  oHS, oVS, oBLANK_n, oX, oY, oADDR, oLINE_START, oFRAME_START
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Free-running VGA raster generator: sync/blank strobes, pixel coordinates and
// linear frame-buffer address, all registered from one counter state.
module vga_timing_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int ADDR_W   = 19
) (
    input  logic         iVGA_CLK,
    input  logic         iRST_n,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    localparam longint PIX_COUNT = longint'(H_ACTIVE) * longint'(V_ACTIVE);
    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    if (PIX_COUNT > ADDR_SPAN) begin : g_addr_w_check
        $error("vga_timing_generator: ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cnt_w_check
        $error("vga_timing_generator: raster totals exceed 10-bit coordinates");
    end

    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    logic h_wrap, v_wrap, active, origin, in_hs, in_vs;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign in_hs  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign in_vs  = (v_cnt >= VS_START) && (v_cnt < VS_END);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_cnt            <= '0;
            v_cnt            <= '0;
            addr_cnt         <= '0;
            vga.oHS          <= ~SYNC_ACT;
            vga.oVS          <= ~SYNC_ACT;
            vga.oBLANK_n     <= 1'b0;
            vga.oX           <= '0;
            vga.oY           <= '0;
            vga.oADDR        <= '0;
            vga.oLINE_START  <= 1'b0;
            vga.oFRAME_START <= 1'b0;
        end else begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end

            vga.oHS          <= in_hs ? SYNC_ACT : ~SYNC_ACT;
            vga.oVS          <= in_vs ? SYNC_ACT : ~SYNC_ACT;
            vga.oBLANK_n     <= active;
            vga.oX           <= h_cnt;
            vga.oY           <= v_cnt;
            vga.oLINE_START  <= (h_cnt == 10'd0);
            vga.oFRAME_START <= origin;

            // addr_cnt always points at the next active pixel; oADDR freezes in blanking
            if (origin) begin
                vga.oADDR <= '0;
                addr_cnt  <= ADDR_W'(1);
            end else if (active) begin
                vga.oADDR <= addr_cnt;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
            end
        end
    end
endmodule
